pipe_stage_buf: RTL and testbench

Parametrised pipeline stage register carrying the register-writeback bundle (we, waddr, wdata) between two pipeline stages. It generalises the fixed 32-bit EX/MEM latch with a valid/ready handshake, a two-entry skid buffer so that in_ready is driven from a flop, and a synchronous flush. It is instantiated between any two stages (EX/MEM, MEM/WB) so that back-pressure and squash work without combinational ready chains.

---
 rtl/pipe_stage_buf_if.sv | 15 +
 rtl/pipe_stage_buf.sv | 105 ++++++++++
 tb/tb_pipe_stage_buf.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_if.sv
// Writeback-bundle link (valid/ready plus we/waddr/wdata) between two pipeline stages.
// master drives the bundle and valid; slave returns ready.
interface pipe_stage_buf_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              valid;
   logic              ready;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;

   modport master (output valid, output we, output waddr, output wdata, input ready);
   modport slave  (input valid, input we, input waddr, input wdata, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register for the writeback bundle with a two-entry skid buffer and flush.
// Define PIPE_STAGE_STAT_EN to add the saturating stall_cnt output.
//
// state | meaning
// EMPTY | nothing held, ready
// ONE   | main entry valid, ready
// FULL  | main and skid valid, not ready
module pipe_stage_buf #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int STAT_W = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   pipe_stage_buf_if.slave  up,
   pipe_stage_buf_if.master dn
`ifdef PIPE_STAGE_STAT_EN
   ,
   output logic [STAT_W-1:0] stall_cnt
`endif
);

   // Encoding is {skid_valid, main_valid}, so the state bits are the valid flops.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } state_t;

   state_t            state;
   logic              main_we;
   logic [ADDR_W-1:0] main_waddr;
   logic [DATA_W-1:0] main_wdata;
   logic              skid_we;
   logic [ADDR_W-1:0] skid_waddr;
   logic [DATA_W-1:0] skid_wdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= EMPTY;
         main_we    <= 1'b0;
         main_waddr <= '0;
         main_wdata <= '0;
         skid_we    <= 1'b0;
         skid_waddr <= '0;
         skid_wdata <= '0;
      end else if (flush) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (up.valid) begin
                  main_we    <= up.we;
                  main_waddr <= up.waddr;
                  main_wdata <= up.wdata;
                  state      <= ONE;
               end
            end
            ONE: begin
               if (up.valid && dn.ready) begin
                  main_we    <= up.we;
                  main_waddr <= up.waddr;
                  main_wdata <= up.wdata;
               end else if (up.valid) begin
                  skid_we    <= up.we;
                  skid_waddr <= up.waddr;
                  skid_wdata <= up.wdata;
                  state      <= FULL;
               end else if (dn.ready) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               // Upstream sees ready low here, so only the drain can happen.
               if (dn.ready) begin
                  main_we    <= skid_we;
                  main_waddr <= skid_waddr;
                  main_wdata <= skid_wdata;
                  state      <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign up.ready = ~state[1];
   assign dn.valid = state[0];
   assign dn.we    = main_we & state[0];
   assign dn.waddr = main_waddr;
   assign dn.wdata = main_wdata;

`ifdef PIPE_STAGE_STAT_EN
   // Flush deliberately leaves the statistic alone; only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (state[0] && !dn.ready && (stall_cnt != {STAT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: vector table plus flush, reset-in-FULL and stall-counter sequences.
module tb_pipe_stage_buf;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int STAT_W = 4;

   logic clk;
   logic rst_n;
   logic flush;

   pipe_stage_buf_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) up_if ();
   pipe_stage_buf_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dn_if ();

`ifdef PIPE_STAGE_STAT_EN
   logic [STAT_W-1:0] stall_cnt;
`endif

   pipe_stage_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STAT_W(STAT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .up    (up_if),
      .dn    (dn_if)
`ifdef PIPE_STAGE_STAT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic              rst_n;
      logic              flush;
      logic              iv;
      logic              we;
      logic [ADDR_W-1:0] wa;
      logic [DATA_W-1:0] wd;
      logic              ordy;
      logic              e_ov;
      logic              e_ir;
      logic              e_we;
      logic [ADDR_W-1:0] e_wa;
      logic [DATA_W-1:0] e_wd;
   } vec_t;

   vec_t vq[$];
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic drive(input logic r, input logic f, input logic iv, input logic we,
                        input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd, input logic ordy);
      rst_n          = r;
      flush          = f;
      up_if.valid    = iv;
      up_if.we       = we;
      up_if.waddr    = wa;
      up_if.wdata    = wd;
      dn_if.ready    = ordy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic f, input logic iv, input logic we,
                      input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd, input logic ordy,
                      input logic e_ov, input logic e_ir, input logic e_we,
                      input logic [ADDR_W-1:0] e_wa, input logic [DATA_W-1:0] e_wd);
      vq.push_back('{r, f, iv, we, wa, wd, ordy, e_ov, e_ir, e_we, e_wa, e_wd});
   endtask

   task automatic chk_out(input string tag, input logic e_ov, input logic e_ir, input logic e_we,
                          input logic [ADDR_W-1:0] e_wa, input logic [DATA_W-1:0] e_wd);
      chk({tag, ".out_valid"}, 64'(dn_if.valid), 64'(e_ov));
      chk({tag, ".in_ready"},  64'(up_if.ready), 64'(e_ir));
      chk({tag, ".out_we"},    64'(dn_if.we),    64'(e_we));
      chk({tag, ".out_waddr"}, 64'(dn_if.waddr), 64'(e_wa));
      chk({tag, ".out_wdata"}, 64'(dn_if.wdata), 64'(e_wd));
   endtask

   initial begin
      int leak;
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

      // reset, then single bundle
      add(0,0,0,0, 5'd0, 32'h0,        1, 0,1,0, 5'd0,  32'h0);
      add(0,0,0,0, 5'd0, 32'h0,        1, 0,1,0, 5'd0,  32'h0);
      add(1,0,1,1, 5'd3, 32'hDEADBEEF, 1, 1,1,1, 5'd3,  32'hDEADBEEF);
      // back-to-back stream
      add(1,0,1,1, 5'd10, 32'hA0,      1, 1,1,1, 5'd10, 32'hA0);
      add(1,0,1,1, 5'd11, 32'hA1,      1, 1,1,1, 5'd11, 32'hA1);
      add(1,0,1,1, 5'd12, 32'hA2,      1, 1,1,1, 5'd12, 32'hA2);
      add(1,0,1,1, 5'd13, 32'hA3,      1, 1,1,1, 5'd13, 32'hA3);
      add(1,0,0,0, 5'd0,  32'h0,       1, 0,1,0, 5'd13, 32'hA3);
      // bubble
      add(1,0,1,0, 5'd7,  32'h55,      1, 1,1,0, 5'd7,  32'h55);
      add(1,0,0,0, 5'd0,  32'h0,       1, 0,1,0, 5'd7,  32'h55);
      // back-pressure: A, B fill, C held upstream until in_ready returns
      add(1,0,1,1, 5'd5,  32'h11,      0, 1,1,1, 5'd5,  32'h11);
      add(1,0,1,1, 5'd6,  32'h22,      0, 1,0,1, 5'd5,  32'h11);
      add(1,0,1,1, 5'd7,  32'h33,      0, 1,0,1, 5'd5,  32'h11);
      add(1,0,1,1, 5'd7,  32'h33,      1, 1,1,1, 5'd6,  32'h22);
      add(1,0,1,1, 5'd7,  32'h33,      1, 1,1,1, 5'd7,  32'h33);
      add(1,0,0,0, 5'd0,  32'h0,       1, 0,1,0, 5'd7,  32'h33);
      // ONE with neither transfer holds
      add(1,0,1,1, 5'd8,  32'h44,      0, 1,1,1, 5'd8,  32'h44);
      add(1,0,0,1, 5'd9,  32'h99,      0, 1,1,1, 5'd8,  32'h44);
      add(1,0,0,0, 5'd0,  32'h0,       1, 0,1,0, 5'd8,  32'h44);

      #1;
      foreach (vq[i]) begin
         drive(vq[i].rst_n, vq[i].flush, vq[i].iv, vq[i].we, vq[i].wa, vq[i].wd, vq[i].ordy);
         step();
         chk_out($sformatf("vec%0d", i), vq[i].e_ov, vq[i].e_ir, vq[i].e_we, vq[i].e_wa, vq[i].e_wd);
      end

      // flush while FULL with C offered: nothing survives, data fields untouched
      drive(1,0,1,1, 5'd1, 32'h100, 0); step();
      drive(1,0,1,1, 5'd2, 32'h200, 0); step();
      chk("flush_pre.in_ready", 64'(up_if.ready), 64'(0));
      drive(1,1,1,1, 5'd3, 32'h300, 0); step();
      chk_out("flush", 1'b0, 1'b1, 1'b0, 5'd1, 32'h100);
      leak = 0;
      drive(1,0,0,0, 5'd0, 32'h0, 1);
      for (int c = 0; c < 5; c++) begin
         step();
         if (dn_if.valid) leak++;
      end
      chk("flush_no_leak", 64'(leak), 64'(0));

      // reset while FULL
      drive(1,0,1,1, 5'd4, 32'h400, 0); step();
      drive(1,0,1,1, 5'd5, 32'h500, 0); step();
      drive(0,0,1,1, 5'd6, 32'h600, 0); step();
      chk_out("rst_full", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);

`ifdef PIPE_STAGE_STAT_EN
      chk("stall_rst", 64'(stall_cnt), 64'(0));
      drive(1,0,1,1, 5'd2, 32'h77, 0); step();
      drive(1,0,0,0, 5'd0, 32'h0, 0);
      for (int c = 0; c < 5; c++) step();
      chk("stall_5", 64'(stall_cnt), 64'(5));
      for (int c = 0; c < 15; c++) step();
      chk("stall_sat", 64'(stall_cnt), 64'(15));
      drive(1,1,0,0, 5'd0, 32'h0, 0); step();
      chk("stall_flush", 64'(stall_cnt), 64'(15));
      drive(0,0,0,0, 5'd0, 32'h0, 0); step();
      chk("stall_clr", 64'(stall_cnt), 64'(0));
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
